pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Program-counter / fetch controller: the supplier side of the CPU fetch interface.
//  Consumes the core's next-PC (AddrOut) and PCWrite; drives the fetch address (AddrIn) into the core.
//  Adds reset vector, start/stop control, an end-of-program halt, misalignment trap and fetch/stall counters.
//  Sits in the top-level wrapper between the test harness and the pipeline core.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  fetch address loaded at reset and in IDLE
//  IMEM_DEPTH    256            instruction memory size in words; fetch at or beyond RESET_VECTOR+4*IMEM_DEPTH halts
//  CNT_W         16             width of fetch_cnt_o / stall_cnt_o (saturating)
// PORTS
//  clk              in   1      clock, rising edge
//  rst_n            in   1      asynchronous active-low reset
//  start_i          in   1      pulse: leave IDLE and begin fetching
//  stop_i           in   1      level: force HALT at next edge (any non-IDLE state)
//  next_addr_i      in   32     core next-PC (core AddrOut)
//  pc_write_i       in   1      core PCWrite; 0 = load-use stall, hold PC
//  addr_o           out  32     current fetch address (to core AddrIn)
//  fetch_valid_o    out  1      1 while in RUN: addr_o is a live fetch
//  halted_o         out  1      1 in HALT
//  err_o            out  1      1 in ERR (misaligned next PC)
//  fetch_cnt_o      out  CNT_W  accepted PC updates since start
//  stall_cnt_o      out  CNT_W  RUN cycles with pc_write_i=0
// BEHAVIOUR
//  - Reset (async assert, sync-released in effect by clk): state=IDLE, addr_o=RESET_VECTOR, all flags 0, counters 0.
//  - States: IDLE -> RUN on start_i. RUN -> HALT on stop_i | end-of-program. RUN -> ERR on misalign.
//    HALT/ERR are terminal; exit only via rst_n. start_i in RUN/HALT/ERR is ignored.
//  - RUN, per rising edge, priority top-down:
//    1 stop_i: -> HALT, addr_o held.
//    2 pc_write_i=0: addr_o held, stall_cnt_o+1.
//    3 next_addr_i[1:0]!=0: -> ERR, addr_o held (bad address never driven).
//    4 next_addr_i >= RESET_VECTOR+4*IMEM_DEPTH (32-bit unsigned compare, bound computed in 33 bits): -> HALT, addr_o held.
//    5 else addr_o<=next_addr_i, fetch_cnt_o+1.
//  - Latency: accepted next_addr_i appears on addr_o one cycle later; no combinational path from inputs to addr_o.
//  - Counters saturate at all-ones, never wrap; frozen outside RUN. start_i in IDLE clears both counters.
//  - fetch_valid_o/halted_o/err_o are decoded from registered state (one-hot outputs, mutually exclusive).
//  - stop_i and start_i in the same IDLE cycle: start wins, stop acts next cycle.
//  - rst_n asserted mid-RUN: immediate return to reset values regardless of clk.
// CONFIGURATION
//  PC_BREAKPOINT_EN defined: adds ports bp_en_i (in,1), bp_addr_i (in,32), bp_hit_o (out,1).
//    In RUN, a would-be-accepted next_addr_i == bp_addr_i with bp_en_i=1 -> HALT with addr_o=bp_addr_i loaded,
//    fetch_cnt_o+1, bp_hit_o=1 (sticky until reset). Priority between steps 4 and 5.
//  Not defined: ports absent, no breakpoint logic; behaviour exactly as above.
// STRUCTURE
//  - pc_fetch_pkg: state enum (IDLE, RUN, HALT, ERR), encoding width, ADDR_W=32, WORD_BYTES=4.
//  - Sub-module pc_sat_counter (parameter CNT_W; inc, clr, rst_n, clk -> cnt), instanced twice.
//  - FSM, address register and compare logic stay in pc_fetch_ctrl.
// TESTING
//  1 Reset: rst_n=0 -> addr_o=0, fetch_valid_o=0, counters 0; hold IDLE 5 cycles with next_addr_i=8,pc_write_i=1 -> addr_o stays 0.
//  2 Stream: start_i, then next_addr_i=4,8,12 with pc_write_i=1 -> addr_o 4,8,12 on successive cycles, fetch_cnt_o=3.
//  3 Stall: pc_write_i=0 for 2 cycles at addr_o=8 -> addr_o holds 8, stall_cnt_o=2, fetch_cnt_o unchanged.
//  4 End/err: IMEM_DEPTH=4, next_addr_i=16 -> halted_o=1, addr_o=12; new run with next_addr_i=6 -> err_o=1, addr_o unchanged.
//  5 CNT_W=4: 20 accepted updates -> fetch_cnt_o=15; stop_i -> halted_o=1, counters frozen; rst_n mid-RUN -> all zero.
//  6 PC_BREAKPOINT_EN: bp_en_i=1, bp_addr_i=8, stream 4,8 -> addr_o=8, halted_o=1, bp_hit_o=1, fetch_cnt_o=2.

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the program-counter / fetch controller.
package pc_fetch_ctrl_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ALIGN_W    = 2;
  localparam int unsigned STATE_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2,
    StErr  = 2'd3
  } fetch_state_e;

  // One-past-last fetch address, kept in ADDR_W+1 bits so a region that ends at 4 GiB
  // never wraps to a small bound.
  function automatic logic [ADDR_W:0] end_addr(input logic [ADDR_W-1:0] base,
                                               input int unsigned depth);
    return {1'b0, base} + ((ADDR_W+1)'(depth) * (ADDR_W+1)'(WORD_BYTES));
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch bus between the PC supplier (master) and the pipeline core (slave).
interface pc_fetch_ctrl_if;
  import pc_fetch_ctrl_pkg::*;

  logic [ADDR_W-1:0] next_addr;
  logic              pc_write;
  logic [ADDR_W-1:0] addr;
  logic              fetch_valid;

  modport master (
    input  next_addr,
    input  pc_write,
    output addr,
    output fetch_valid
  );

  modport slave (
    output next_addr,
    output pc_write,
    input  addr,
    input  fetch_valid
  );

endinterface

// File: rtl/pc_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pc_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter / fetch controller feeding the core's fetch address.
// Optional PC breakpoint halt enabled by defining PC_BREAKPOINT_EN.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned       IMEM_DEPTH   = 256,
  parameter int unsigned       CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              stop_i,
`ifdef PC_BREAKPOINT_EN
  input  logic              bp_en_i,
  input  logic [ADDR_W-1:0] bp_addr_i,
  output logic              bp_hit_o,
`endif
  output logic              halted_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  fetch_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  pc_fetch_ctrl_if.master   fetch
);

  localparam logic [ADDR_W:0] EndBound = end_addr(RESET_VECTOR, IMEM_DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fetch_inc, stall_inc, cnt_clr;
  logic              misaligned, past_end;

  assign misaligned = (fetch.next_addr[ALIGN_W-1:0] != '0);
  assign past_end   = ({1'b0, fetch.next_addr} >= EndBound);

`ifdef PC_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d;
  logic bp_match;
  assign bp_match = bp_en_i && (fetch.next_addr == bp_addr_i);
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    fetch_inc = 1'b0;
    stall_inc = 1'b0;
    cnt_clr   = 1'b0;
`ifdef PC_BREAKPOINT_EN
    bp_hit_d  = bp_hit_q;
`endif
    unique case (state_q)
      StIdle: begin
        addr_d = RESET_VECTOR;
        // A stop in the same cycle is ignored; it takes effect once in RUN.
        if (start_i) begin
          state_d = StRun;
          cnt_clr = 1'b1;
        end
      end
      StRun: begin
        if (stop_i) begin
          state_d = StHalt;
        end else if (!fetch.pc_write) begin
          stall_inc = 1'b1;
        end else if (misaligned) begin
          state_d = StErr;
        end else if (past_end) begin
          state_d = StHalt;
`ifdef PC_BREAKPOINT_EN
        end else if (bp_match) begin
          state_d   = StHalt;
          addr_d    = fetch.next_addr;
          fetch_inc = 1'b1;
          bp_hit_d  = 1'b1;
`endif
        end else begin
          addr_d    = fetch.next_addr;
          fetch_inc = 1'b1;
        end
      end
      StHalt, StErr: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

`ifdef PC_BREAKPOINT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_hit_q <= 1'b0;
    end else begin
      bp_hit_q <= bp_hit_d;
    end
  end

  assign bp_hit_o = bp_hit_q;
`endif

  pc_sat_counter #(
    .CNT_W (CNT_W)
  ) u_fetch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fetch_inc),
    .clr   (cnt_clr),
    .cnt   (fetch_cnt_o)
  );

  pc_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .clr   (cnt_clr),
    .cnt   (stall_cnt_o)
  );

  assign fetch.addr        = addr_q;
  assign fetch.fetch_valid = (state_q == StRun);
  assign halted_o          = (state_q == StHalt);
  assign err_o             = (state_q == StErr);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed, table-driven bench for pc_fetch_ctrl (IMEM_DEPTH=4, CNT_W=4).
module tb_pc_fetch_ctrl;

  localparam int unsigned CntW      = 4;
  localparam int unsigned ImemDepth = 4;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            stop;
  logic            halted;
  logic            err;
  logic [CntW-1:0] fetch_cnt;
  logic [CntW-1:0] stall_cnt;
`ifdef PC_BREAKPOINT_EN
  logic            bp_en;
  logic [31:0]     bp_addr;
  logic            bp_hit;
`endif

  int checks;
  int errors;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl #(
    .RESET_VECTOR (32'h0000_0000),
    .IMEM_DEPTH   (ImemDepth),
    .CNT_W        (CntW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .stop_i      (stop),
`ifdef PC_BREAKPOINT_EN
    .bp_en_i     (bp_en),
    .bp_addr_i   (bp_addr),
    .bp_hit_o    (bp_hit),
`endif
    .halted_o    (halted),
    .err_o       (err),
    .fetch_cnt_o (fetch_cnt),
    .stall_cnt_o (stall_cnt),
    .fetch       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          start;
    bit          stop;
    logic [31:0] na;
    bit          pw;
    logic [31:0] e_addr;
    bit          e_valid;
    bit          e_halt;
    bit          e_err;
    int          e_fc;
    int          e_sc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit st, bit sp, logic [31:0] na, bit pw,
                              logic [31:0] ea, bit ev, bit eh, bit ee, int efc, int esc);
    vec_t v;
    v.rst = rst; v.start = st; v.stop = sp; v.na = na; v.pw = pw;
    v.e_addr = ea; v.e_valid = ev; v.e_halt = eh; v.e_err = ee; v.e_fc = efc; v.e_sc = esc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " addr"}, bus.addr, v.e_addr);
    chk({tag, " valid"}, 32'(bus.fetch_valid), 32'(v.e_valid));
    chk({tag, " halted"}, 32'(halted), 32'(v.e_halt));
    chk({tag, " err"}, 32'(err), 32'(v.e_err));
    chk({tag, " fetch_cnt"}, 32'(fetch_cnt), 32'(v.e_fc));
    chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(v.e_sc));
  endtask

  // Called at a negedge: drive, let one rising edge pass, check just after it.
  task automatic apply(input string tag, input vec_t v);
    rst_n         = !v.rst;
    start         = v.start;
    stop          = v.stop;
    bus.next_addr = v.na;
    bus.pc_write  = v.pw;
    @(posedge clk);
    #1;
    chk_all(tag, v);
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   efc;
    checks = 0;
    errors = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    bus.next_addr = 32'd8; bus.pc_write = 1'b1;
`ifdef PC_BREAKPOINT_EN
    bp_en = 1'b0; bp_addr = 32'd0;
`endif
    #1;
    chk_all("async reset", mk(1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0));

    //               rst st sp na  pw  addr v  h  e  fc sc
    vecs.push_back(mk(1, 0, 0, 8,  1,  0,  0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8,  1,  0,  1, 0, 0, 0, 0));   // start: addr still reset vector
    vecs.push_back(mk(0, 0, 0, 4,  1,  4,  1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8,  1,  8,  1, 0, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 12, 0,  8,  1, 0, 0, 2, 1));   // stall
    vecs.push_back(mk(0, 0, 0, 12, 0,  8,  1, 0, 0, 2, 2));
    vecs.push_back(mk(0, 0, 0, 12, 1,  12, 1, 0, 0, 3, 2));
    vecs.push_back(mk(0, 0, 0, 16, 1,  12, 0, 1, 0, 3, 2));   // end of imem
    vecs.push_back(mk(0, 1, 0, 4,  1,  12, 0, 1, 0, 3, 2));   // start ignored in HALT
    vecs.push_back(mk(1, 0, 0, 4,  1,  0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4,  1,  0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 6,  1,  0,  0, 0, 1, 0, 0));   // misaligned
    vecs.push_back(mk(0, 1, 0, 4,  1,  0,  0, 0, 1, 0, 0));   // ERR is terminal
    vecs.push_back(mk(0, 0, 0, 4,  0,  0,  0, 0, 1, 0, 0));   // no stall count in ERR
    vecs.push_back(mk(1, 0, 0, 4,  1,  0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4,  1,  0,  1, 0, 0, 0, 0));

    @(negedge clk);
    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

    // Fetch counter saturates at 15 after 20 accepted updates.
    for (int i = 1; i <= 20; i++) begin
      efc = (i > 15) ? 15 : i;
      apply($sformatf("sat%0d", i), mk(0, 0, 0, 4, 1, 4, 1, 0, 0, efc, 0));
    end
    // Stop has priority over a stall; counters freeze in HALT.
    apply("stop", mk(0, 0, 1, 4, 0, 4, 0, 1, 0, 15, 0));
    apply("frozen", mk(0, 0, 0, 8, 0, 4, 0, 1, 0, 15, 0));

    // start and stop together in IDLE: start wins, stop acts on the next edge.
    apply("rst2", mk(1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0));
    apply("start+stop", mk(0, 1, 1, 4, 1, 0, 1, 0, 0, 0, 0));
    apply("stop next", mk(0, 0, 1, 4, 1, 0, 0, 1, 0, 0, 0));

    // Async reset mid-RUN takes effect with no clock edge.
    apply("rst3", mk(1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0));
    apply("run3", mk(0, 1, 0, 4, 1, 0, 1, 0, 0, 0, 0));
    apply("fetch3", mk(0, 0, 0, 8, 1, 8, 1, 0, 0, 1, 0));
    apply("stall3", mk(0, 0, 0, 8, 0, 8, 1, 0, 0, 1, 1));
    rst_n = 1'b0;
    #1;
    chk_all("mid-run reset", mk(1, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);

`ifdef PC_BREAKPOINT_EN
    apply("bp start", mk(0, 1, 0, 4, 1, 0, 1, 0, 0, 0, 0));
    chk("bp_hit clear", 32'(bp_hit), 32'd0);
    bp_en = 1'b1; bp_addr = 32'd8;
    apply("bp 4", mk(0, 0, 0, 4, 1, 4, 1, 0, 0, 1, 0));
    apply("bp 8", mk(0, 0, 0, 8, 1, 8, 0, 1, 0, 2, 0));
    chk("bp_hit", 32'(bp_hit), 32'd1);
    apply("bp hold", mk(0, 0, 0, 12, 1, 8, 0, 1, 0, 2, 0));
    chk("bp_hit sticky", 32'(bp_hit), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
